// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, fixed latency,
// Stall holds the pipeline until the Ready pulse.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   MemRead   : load request
//   MemWrite  : store request
//   Addr      : byte address (word index Addr[ADDR_W+1:2])
//   WriteData : store data
//   ReadData  : load data, valid with Ready, held afterwards
//   Ready     : one-cycle completion pulse
//   Stall     : freeze upstream pipeline registers while high
//   AddrErr   : one-cycle pulse on a rejected request
//
// Build option: define DMEM_ERR_CHECK_EN to reject misaligned,
// out-of-range and read+write requests. Left undefined, addresses are
// truncated, MemWrite wins over MemRead and AddrErr stays 0.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Ready,
    output logic              Stall,
    output logic              AddrErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit LAT1 = (LATENCY == 1);
    localparam int CNT_I = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [3:0] CNT_INIT = CNT_I[3:0];

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_addr_err;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic              w_req;
    logic              w_bad;
    logic              w_accept;
    logic              w_go_resp;
    logic              w_acc_wr;
    logic [ADDR_W-1:0] w_acc_idx;
    logic [DATA_W-1:0] w_acc_wdata;

    assign w_req = MemRead | MemWrite;

`ifdef DMEM_ERR_CHECK_EN
    assign w_bad = (Addr[1:0] != 2'b00)
                 | (Addr[31:ADDR_W+2] != '0)
                 | (MemRead & MemWrite);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{Addr[31:ADDR_W+2], Addr[1:0]};
    assign w_bad = 1'b0;
`endif

    // rst gates the combinational paths so nothing is accepted or
    // written while reset is held low.
    assign w_accept = rst & (r_state == IDLE) & w_req & ~w_bad;

    // With single-cycle latency the access happens on the acceptance
    // edge itself, so it must use the live inputs, not the latches.
    assign w_go_resp = LAT1 ? w_accept
                     : (rst & (r_state == BUSY) & (r_cnt == 4'd0));
    assign w_acc_wr    = LAT1 ? MemWrite : r_op_wr;
    assign w_acc_idx   = LAT1 ? Addr[ADDR_W+1:2] : r_idx;
    assign w_acc_wdata = LAT1 ? WriteData : r_wdata;

    always_ff @(posedge clk) begin
        if (w_go_resp && w_acc_wr) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_op_wr    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_bad) begin
                            r_addr_err <= 1'b1;
                        end else begin
                            r_op_wr <= MemWrite;
                            r_idx   <= Addr[ADDR_W+1:2];
                            r_wdata <= WriteData;
                            if (LAT1) begin
                                r_state <= RESP;
                            end else begin
                                r_state <= BUSY;
                                r_cnt   <= CNT_INIT;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_go_resp && !w_acc_wr) begin
                r_rdata <= r_mem[w_acc_idx];
            end
        end
    end

    assign ReadData = r_rdata;
    assign Ready    = (r_state == RESP);
    assign Stall    = w_accept | (r_state == BUSY);
    assign AddrErr  = r_addr_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of per-cycle vectors on a
// LATENCY=2 instance, plus reset and LATENCY=1 sequences.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mr, mw;
    logic [31:0] addr, wd;
    logic [31:0] rd;
    logic        rdy, stall, err;

    logic        mr1, mw1;
    logic [31:0] addr1, wd1;
    logic [31:0] rd1;
    logic        rdy1, stall1, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .MemRead(mr), .MemWrite(mw),
        .Addr(addr), .WriteData(wd), .ReadData(rd),
        .Ready(rdy), .Stall(stall), .AddrErr(err)
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .MemRead(mr1), .MemWrite(mw1),
        .Addr(addr1), .WriteData(wd1), .ReadData(rd1),
        .Ready(rdy1), .Stall(stall1), .AddrErr(err1)
    );

    typedef struct {
        logic        mr;
        logic        mw;
        logic [31:0] a;
        logic [31:0] wd;
        logic        st;
        logic        rdy;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic vmr, logic vmw,
                                logic [31:0] va, logic [31:0] vwd,
                                logic vst, logic vrdy,
                                logic [31:0] vrd, logic verr);
        vec_t v;
        v.mr = vmr; v.mw = vmw; v.a = va; v.wd = vwd;
        v.st = vst; v.rdy = vrdy; v.rd = vrd; v.err = verr;
        tbl.push_back(v);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check at negedge, return at posedge+1.
    task automatic run(string n, logic vmr, logic vmw,
                       logic [31:0] va, logic [31:0] vwd,
                       logic vst, logic vrdy,
                       logic [31:0] vrd, logic verr);
        mr = vmr; mw = vmw; addr = va; wd = vwd;
        @(negedge clk);
        chk({n, " stall"}, {31'd0, stall}, {31'd0, vst});
        chk({n, " ready"}, {31'd0, rdy}, {31'd0, vrdy});
        chk({n, " rdata"}, rd, vrd);
        chk({n, " adderr"}, {31'd0, err}, {31'd0, verr});
        @(posedge clk);
        #1;
    endtask

    logic [31:0] last_rd;

    initial begin
        rst = 1'b0;
        mr = 0; mw = 0; addr = 0; wd = 0;
        mr1 = 0; mw1 = 0; addr1 = 0; wd1 = 0;

        // SW 0x10 <- DEADBEEF, then LW 0x10, then 5 idle cycles
        add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
        add(0, 1, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0,        0);
        add(0, 1, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0,        0);
        add(0, 1, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0,        0);
        add(1, 0, 32'h10, 32'h0,        1, 0, 32'h0,        0);
        add(1, 0, 32'h10, 32'h0,        1, 0, 32'h0,        0);
        add(1, 0, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 32'h0, 32'h0, 0, 0, 32'hDEADBEEF, 0);
`ifdef DMEM_ERR_CHECK_EN
        // misaligned, out of range, read+write: each pulses AddrErr
        add(1, 0, 32'h11,  32'h0, 0, 0, 32'hDEADBEEF, 0);
        add(0, 0, 32'h0,   32'h0, 0, 0, 32'hDEADBEEF, 1);
        add(0, 0, 32'h0,   32'h0, 0, 0, 32'hDEADBEEF, 0);
        add(1, 0, 32'h400, 32'h0, 0, 0, 32'hDEADBEEF, 0);
        add(0, 0, 32'h0,   32'h0, 0, 0, 32'hDEADBEEF, 1);
        add(0, 0, 32'h0,   32'h0, 0, 0, 32'hDEADBEEF, 0);
        add(1, 1, 32'h10,  32'h0, 0, 0, 32'hDEADBEEF, 0);
        add(0, 0, 32'h0,   32'h0, 0, 0, 32'hDEADBEEF, 1);
        add(1, 0, 32'h10,  32'h0, 1, 0, 32'hDEADBEEF, 0);
        add(1, 0, 32'h10,  32'h0, 1, 0, 32'hDEADBEEF, 0);
        add(1, 0, 32'h10,  32'h0, 0, 1, 32'hDEADBEEF, 0);
        last_rd = 32'hDEADBEEF;
`else
        // truncation of 0x401 to word 0, then MemWrite priority
        add(0, 1, 32'h401, 32'hA5A5A5A5, 1, 0, 32'hDEADBEEF, 0);
        add(0, 1, 32'h401, 32'hA5A5A5A5, 1, 0, 32'hDEADBEEF, 0);
        add(0, 1, 32'h401, 32'hA5A5A5A5, 0, 1, 32'hDEADBEEF, 0);
        add(1, 0, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF, 0);
        add(1, 0, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF, 0);
        add(1, 0, 32'h0,   32'h0,        0, 1, 32'hA5A5A5A5, 0);
        add(1, 1, 32'h8,   32'h55,       1, 0, 32'hA5A5A5A5, 0);
        add(1, 1, 32'h8,   32'h55,       1, 0, 32'hA5A5A5A5, 0);
        add(1, 1, 32'h8,   32'h55,       0, 1, 32'hA5A5A5A5, 0);
        add(1, 0, 32'h8,   32'h0,        1, 0, 32'hA5A5A5A5, 0);
        add(1, 0, 32'h8,   32'h0,        1, 0, 32'hA5A5A5A5, 0);
        add(1, 0, 32'h8,   32'h0,        0, 1, 32'h55,       0);
        last_rd = 32'h55;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst ready", {31'd0, rdy}, 32'd0);
        chk("rst rdata", rd, 32'd0);
        chk("rst adderr", {31'd0, err}, 32'd0);
        chk("rst1 ready", {31'd0, rdy1}, 32'd0);
        chk("rst1 rdata", rd1, 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            run($sformatf("v%0d", i), tbl[i].mr, tbl[i].mw,
                tbl[i].a, tbl[i].wd, tbl[i].st, tbl[i].rdy,
                tbl[i].rd, tbl[i].err);
        end

        // mem[8] = 7, then abort a store of 1 to it with reset
        run("pw0", 0, 1, 32'h20, 32'h7, 1, 0, last_rd, 0);
        run("pw1", 0, 1, 32'h20, 32'h7, 1, 0, last_rd, 0);
        run("pw2", 0, 1, 32'h20, 32'h7, 0, 1, last_rd, 0);
        run("ab0", 0, 1, 32'h20, 32'h1, 1, 0, last_rd, 0);
        @(negedge clk);
        chk("ab busy stall", {31'd0, stall}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ab stall", {31'd0, stall}, 32'd0);
        chk("ab ready", {31'd0, rdy}, 32'd0);
        chk("ab rdata", rd, 32'd0);
        chk("ab adderr", {31'd0, err}, 32'd0);
        mw = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run("ar0", 1, 0, 32'h20, 32'h0, 1, 0, 32'h0, 0);
        run("ar1", 1, 0, 32'h20, 32'h0, 1, 0, 32'h0, 0);
        run("ar2", 1, 0, 32'h20, 32'h0, 0, 1, 32'h7, 0);
        run("ar3", 0, 0, 32'h0,  32'h0, 0, 0, 32'h7, 0);

        // LATENCY=1 instance: SW 0x04, then LW 0x04
        mw1 = 1; addr1 = 32'h4; wd1 = 32'h12345678;
        @(negedge clk);
        chk("l1 sw stall", {31'd0, stall1}, 32'd1);
        chk("l1 sw ready", {31'd0, rdy1}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("l1 sw resp stall", {31'd0, stall1}, 32'd0);
        chk("l1 sw resp ready", {31'd0, rdy1}, 32'd1);
        chk("l1 sw resp rdata", rd1, 32'd0);
        @(posedge clk);
        #1;
        mw1 = 0; mr1 = 1; wd1 = 0;
        @(negedge clk);
        chk("l1 lw stall", {31'd0, stall1}, 32'd1);
        chk("l1 lw ready", {31'd0, rdy1}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("l1 lw resp stall", {31'd0, stall1}, 32'd0);
        chk("l1 lw resp ready", {31'd0, rdy1}, 32'd1);
        chk("l1 lw resp rdata", rd1, 32'h12345678);
        @(posedge clk);
        #1;
        mr1 = 0;
        @(negedge clk);
        chk("l1 idle ready", {31'd0, rdy1}, 32'd0);
        chk("l1 idle rdata", rd1, 32'h12345678);
        chk("l1 adderr", {31'd0, err1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
